// File: rtl/seg_scan_mux.sv
// Multiplexed 7-segment scanner with shadow/active buffers,
// frame-aligned commit and per-slot PWM brightness.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 100000,
  parameter int BRIGHT_W   = 3,
  localparam int AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_en,
  input  logic [BRIGHT_W-1:0]   brightness,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [5:0]            wr_data,
  input  logic                  commit,
  output logic                  busy,
  output logic                  commit_done,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] seg_en,
  output logic [7:0]            seg_out
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int PH = TICK_DIV >> BRIGHT_W;

  typedef enum logic {IDLE, PEND} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  logic [5:0]    shadow [NUM_DIGITS];
  logic [5:0]    active [NUM_DIGITS];

  logic          tick;
  logic          boundary;
  logic          copy;
  logic          wr_ok;
  logic [CW-1:0] phase;
  logic [5:0]    cur;
  logic          lit;

  assign tick     = (cnt == CW'(TICK_DIV - 1));
  assign boundary = tick && (idx == AW'(NUM_DIGITS - 1));
  assign copy     = boundary && ((state == PEND) || commit);
  assign wr_ok    = wr_en && (int'(wr_addr) < NUM_DIGITS);
  assign busy     = (state == PEND);

  // Phase is never wider than BRIGHT_W bits of value, so a
  // zero-extended compare against brightness is exact.
  assign phase = cnt / CW'(PH);
  assign cur   = active[idx];
  assign lit   = disp_en && (phase <= CW'(brightness)) && !cur[5];

  function automatic logic [6:0] dec(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    case (h)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h7B;
      4'hA: s = 7'h7D;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Slot prescaler, digit index and frame-wrap pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) begin
        cnt <= '0;
        if (idx == AW'(NUM_DIGITS - 1)) idx <= '0;
        else                            idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Shadow writes and frame-aligned shadow->active commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      commit_done <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 6'b100000;
        active[i] <= 6'b100000;
      end
    end else begin
      commit_done <= copy;
      if (wr_ok) shadow[wr_addr] <= wr_data;
      if (copy) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
        state <= IDLE;
      end else if (commit) begin
        state <= PEND;
      end
    end
  end

  // Registered tube drive
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_en  <= '0;
      seg_out <= 8'h00;
    end else begin
      seg_en  <= lit ? (NUM_DIGITS'(1) << idx) : '0;
      seg_out <= lit ? {dec(cur[3:0]), cur[4]} : 8'h00;
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 16-cycle slots,
// 2-bit brightness) plus a 5-digit copy for address range.
module tb_seg_scan_mux;

  logic       clk = 1'b0;
  logic       rst;
  logic       disp_en;
  logic [1:0] brightness;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [5:0] wr_data;
  logic       commit;
  logic       busy;
  logic       commit_done;
  logic       frame_start;
  logic [3:0] seg_en;
  logic [7:0] seg_out;

  logic       wr_en2;
  logic [2:0] wr_addr2;
  logic [5:0] wr_data2;
  logic       commit2;
  logic       busy2;
  logic       commit_done2;
  logic       frame_start2;
  logic [4:0] seg_en2;
  logic [7:0] seg_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_mux #(.NUM_DIGITS(4), .TICK_DIV(16), .BRIGHT_W(2)) dut (
    .clk(clk), .rst(rst), .disp_en(disp_en), .brightness(brightness),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .busy(busy), .commit_done(commit_done),
    .frame_start(frame_start), .seg_en(seg_en), .seg_out(seg_out)
  );

  seg_scan_mux #(.NUM_DIGITS(5), .TICK_DIV(16), .BRIGHT_W(2)) dut2 (
    .clk(clk), .rst(rst), .disp_en(disp_en), .brightness(brightness),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .commit(commit2), .busy(busy2), .commit_done(commit_done2),
    .frame_start(frame_start2), .seg_en(seg_en2), .seg_out(seg_out2)
  );

  task automatic write_digit(input logic [1:0] a, input logic [5:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_fs;
    #2;
    checks++;
    if (seg_en !== 4'h0 || seg_out !== 8'h00 || busy !== 1'b0 ||
        commit_done !== 1'b0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got en=%h out=%h busy=%b cd=%b fs=%b want all 0",
               seg_en, seg_out, busy, commit_done, frame_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      exp_fs = (k % 64 == 0);
      checks++;
      if (frame_start !== exp_fs) begin
        errors++;
        $display("FAIL frame_start cycle %0d got %b want %b", k, frame_start, exp_fs);
      end
      checks++;
      if (seg_en !== 4'h0 || seg_out !== 8'h00) begin
        errors++;
        $display("FAIL blank_idle cycle %0d got en=%h out=%h want 0 0", k, seg_en, seg_out);
      end
    end
  endtask

  task automatic test_display();
    logic [7:0] exp_out [4];
    logic [3:0] exp_en;
    bit         got;
    exp_out[0] = 8'h60; exp_out[1] = 8'hDB;
    exp_out[2] = 8'hFA; exp_out[3] = 8'h8E;
    write_digit(2'd0, 6'h01);
    write_digit(2'd1, 6'h12);
    write_digit(2'd2, 6'h0A);
    write_digit(2'd3, 6'h0F);
    pulse_commit();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_commit got %b want 1", busy);
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (commit_done) begin
        got = 1'b1;
        break;
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL busy_hold got %b want 1", busy);
      end
    end
    checks++;
    if (!got || busy !== 1'b0 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL commit_done got done=%b busy=%b fs=%b want 1 0 1", got, busy, frame_start);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      exp_en = 4'h1 << (i / 16);
      checks++;
      if (seg_en !== exp_en || seg_out !== exp_out[i/16]) begin
        errors++;
        $display("FAIL scan cycle %0d got en=%h out=%h want en=%h out=%h",
                 i, seg_en, seg_out, exp_en, exp_out[i/16]);
      end
    end
  endtask

  task automatic test_brightness();
    int exp_on [3];
    int on0;
    bit ok;
    exp_on[0] = 8; exp_on[1] = 4; exp_on[2] = 0;
    for (int t = 0; t < 3; t++) begin
      brightness = (t == 0) ? 2'd1 : 2'd0;
      disp_en    = (t != 2);
      wait_fs(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL pwm_sync case %0d got timeout want frame_start", t);
      end
      on0 = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        if (seg_en[0]) on0++;
      end
      checks++;
      if (on0 !== exp_on[t]) begin
        errors++;
        $display("FAIL pwm_on case %0d got %0d want %0d", t, on0, exp_on[t]);
      end
    end
    brightness = 2'd3;
    disp_en    = 1'b1;
  endtask

  task automatic test_boundary_commit();
    bit ok;
    write_digit(2'd0, 6'h08);
    wait_fs(ok);
    repeat (63) @(negedge clk);
    pulse_commit();
    checks++;
    if (!ok || commit_done !== 1'b1 || frame_start !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL boundary_commit got ok=%b cd=%b fs=%b busy=%b want 1 1 1 0",
               ok, commit_done, frame_start, busy);
    end
    @(negedge clk);
    checks++;
    if (seg_en !== 4'h1 || seg_out !== 8'hFE || commit_done !== 1'b0) begin
      errors++;
      $display("FAIL boundary_apply got en=%h out=%h cd=%b want 1 fe 0",
               seg_en, seg_out, commit_done);
    end
  endtask

  task automatic test_double_commit();
    int n;
    bit ok;
    wait_fs(ok);
    repeat (5) @(negedge clk);
    pulse_commit();
    repeat (10) @(negedge clk);
    pulse_commit();
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL double_pending got ok=%b busy=%b want 1 1", ok, busy);
    end
    n = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (commit_done) n++;
    end
    checks++;
    if (n !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL double_commit got done=%0d busy=%b want 1 0", n, busy);
    end
  endtask

  task automatic test_no_commit();
    int n_old;
    int n_new;
    bit ok;
    write_digit(2'd2, 6'h00);
    wait_fs(ok);
    n_old = 0;
    n_new = 0;
    for (int i = 0; i < 192; i++) begin
      @(negedge clk);
      if (seg_en == 4'h4 && seg_out == 8'hFA) n_old++;
      if (seg_out == 8'hFC) n_new++;
    end
    checks++;
    if (!ok || n_old !== 48 || n_new !== 0) begin
      errors++;
      $display("FAIL no_commit got ok=%b old=%0d new=%0d want 1 48 0", ok, n_old, n_new);
    end
  endtask

  task automatic test_out_of_range();
    int lit;
    int done;
    bit got;
    wr_en2 = 1'b1; wr_addr2 = 3'd5; wr_data2 = 6'h01;
    @(negedge clk);
    wr_addr2 = 3'd7;
    @(negedge clk);
    wr_en2 = 1'b0;
    commit2 = 1'b1;
    @(negedge clk);
    commit2 = 1'b0;
    lit = 0;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (seg_en2 != 5'h0) lit++;
      if (commit_done2) done++;
    end
    checks++;
    if (lit !== 0 || done !== 1) begin
      errors++;
      $display("FAIL oor_drop got lit=%0d done=%0d want 0 1", lit, done);
    end
    wr_en2 = 1'b1; wr_addr2 = 3'd4; wr_data2 = 6'h01;
    @(negedge clk);
    wr_en2 = 1'b0;
    commit2 = 1'b1;
    @(negedge clk);
    commit2 = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (commit_done2) begin
        got = 1'b1;
        break;
      end
    end
    @(negedge clk);
    lit = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (seg_en2 == 5'h10 && seg_out2 == 8'h60) lit++;
    end
    checks++;
    if (!got || lit !== 16) begin
      errors++;
      $display("FAIL last_digit got done=%b lit=%0d want 1 16", got, lit);
    end
  endtask

  task automatic test_reset_midframe();
    int lit;
    int done;
    bit ok;
    wait_fs(ok);
    repeat (3) @(negedge clk);
    pulse_commit();
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || seg_en !== 4'h1) begin
      errors++;
      $display("FAIL pre_reset got ok=%b busy=%b en=%h want 1 1 1", ok, busy, seg_en);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (seg_en !== 4'h0 || seg_out !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got en=%h out=%h busy=%b want 0 0 0", seg_en, seg_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    lit = 0;
    done = 0;
    for (int i = 0; i < 140; i++) begin
      @(negedge clk);
      if (seg_en != 4'h0) lit++;
      if (commit_done) done++;
    end
    checks++;
    if (lit !== 0 || done !== 0) begin
      errors++;
      $display("FAIL post_reset got lit=%0d done=%0d want 0 0", lit, done);
    end
  endtask

  initial begin
    rst = 1'b1;
    disp_en = 1'b1;
    brightness = 2'd3;
    wr_en = 1'b0; wr_addr = 2'd0; wr_data = 6'h00; commit = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = 3'd0; wr_data2 = 6'h00; commit2 = 1'b0;
    test_reset();
    test_display();
    test_brightness();
    test_boundary_commit();
    test_double_commit();
    test_no_commit();
    test_out_of_range();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
